// File: rtl/avmm_button_led_pio_if.sv
// Avalon-MM responder bus bundle for the button/LED PIO.
// The bus master drives address/strobes/writedata; the responder returns read data.
interface avmm_button_led_pio_if;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;

  modport master (
    output avs_address,
    output avs_read,
    output avs_write,
    output avs_writedata,
    input  avs_readdata,
    input  avs_readdatavalid
  );

  modport slave (
    input  avs_address,
    input  avs_read,
    input  avs_write,
    input  avs_writedata,
    output avs_readdata,
    output avs_readdatavalid
  );
endinterface

// File: rtl/avmm_button_led_pio.sv
// Avalon-MM switch/LED PIO: debounced switch inputs with sticky rising-edge
// capture and maskable level IRQ, plus a read/write LED output register.
module avmm_button_led_pio #(
  parameter int unsigned      WIDTH           = 8,
  parameter int unsigned      DEBOUNCE_CYCLES = 50000,
  parameter logic [WIDTH-1:0] LED_RESET       = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  avmm_button_led_pio_if.slave avs,
  output logic                 irq,
  input  logic [WIDTH-1:0]     sw_in,
  output logic [WIDTH-1:0]     led_out
);

  localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ADDR_SW   = 2'd0;
  localparam logic [1:0] ADDR_LED  = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  logic [WIDTH-1:0] sync_q1;
  logic [WIDTH-1:0] sync_q2;
  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] stable_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] rise;

  logic [WIDTH-1:0] led_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] edge_q;
  logic [WIDTH-1:0] edge_d;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] w1c;
  logic [31:0]      rd_mux;
  logic             rd_accept;
  logic             wr_led;
  logic             wr_mask;
  logic             wr_edge;
  logic             unused_wdata_bits;

  // Two-flop synchronizer for the asynchronous pin inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= sw_in;
      sync_q2 <= sync_q1;
    end
  end

  // A bit only flips once the synced value has disagreed for DEBOUNCE_CYCLES cycles in a row.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < int'(WIDTH); i++) begin
      cnt_d[i] = '0;
      if (sync_q2[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync_q2[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stable_q <= '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign rise = stable_d & ~stable_q;

  // A write with a concurrent read wins; the read is silently dropped.
  assign rd_accept = avs.avs_read && !avs.avs_write;
  assign wr_led    = avs.avs_write && (avs.avs_address == ADDR_LED);
  assign wr_mask   = avs.avs_write && (avs.avs_address == ADDR_MASK);
  assign wr_edge   = avs.avs_write && (avs.avs_address == ADDR_EDGE);
  assign wdata     = avs.avs_writedata[WIDTH-1:0];
  assign w1c       = wr_edge ? wdata : '0;

  assign unused_wdata_bits = ^avs.avs_writedata;

  // A new rising edge is OR-ed in after the clear, so set beats a same-cycle W1C.
  assign edge_d = (edge_q & ~w1c) | rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q  <= LED_RESET;
      mask_q <= '0;
      edge_q <= '0;
      irq    <= 1'b0;
    end else begin
      if (wr_led) begin
        led_q <= wdata;
      end
      if (wr_mask) begin
        mask_q <= wdata;
      end
      edge_q <= edge_d;
      irq    <= |(edge_q & mask_q);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (avs.avs_address)
      ADDR_SW:   rd_mux = 32'(stable_q);
      ADDR_LED:  rd_mux = 32'(led_q);
      ADDR_MASK: rd_mux = 32'(mask_q);
      ADDR_EDGE: rd_mux = 32'(edge_q);
      default:   rd_mux = '0;
    endcase
  end

  // Read data holds between responses; only the valid strobe pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      avs.avs_readdata      <= '0;
      avs.avs_readdatavalid <= 1'b0;
    end else begin
      avs.avs_readdatavalid <= rd_accept;
      if (rd_accept) begin
        avs.avs_readdata <= rd_mux;
      end
    end
  end

  assign led_out = led_q;

endmodule

// File: tb/tb_avmm_button_led_pio.sv
// Directed plus randomized bench for avmm_button_led_pio, checked every cycle
// against a window-based behavioural model of debounce, edge capture and bus.
module tb_avmm_button_led_pio;

  localparam int WIDTH = 8;
  localparam int DEB   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] sw_in;
  logic [WIDTH-1:0] led_out;
  logic             irq;

  avmm_button_led_pio_if bus ();

  avmm_button_led_pio #(
    .WIDTH           (WIDTH),
    .DEBOUNCE_CYCLES (DEB),
    .LED_RESET       (8'h00)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .avs     (bus),
    .irq     (irq),
    .sw_in   (sw_in),
    .led_out (led_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a switch bit is accepted when the last DEB synchronized
  // samples (pins delayed by two clocks) all disagree with the accepted value.
  logic [7:0]  m_stable;
  logic [7:0]  m_led;
  logic [7:0]  m_mask;
  logic [7:0]  m_edge;
  logic        m_irq;
  logic        m_rdv;
  logic [31:0] m_rd;
  logic [7:0]  pin_hist[$];

  task automatic model_reset();
    m_stable = 8'h00;
    m_led    = 8'h00;
    m_mask   = 8'h00;
    m_edge   = 8'h00;
    m_irq    = 1'b0;
    m_rdv    = 1'b0;
    m_rd     = 32'h0;
    pin_hist.delete();
    for (int i = 0; i < 2 + DEB; i++) pin_hist.push_back(8'h00);
  endtask

  function automatic logic [31:0] model_reg(input logic [1:0] a);
    case (a)
      2'd0:    return {24'h0, m_stable};
      2'd1:    return {24'h0, m_led};
      2'd2:    return {24'h0, m_mask};
      default: return {24'h0, m_edge};
    endcase
  endfunction

  task automatic model_step();
    logic [7:0] new_stable;
    logic [7:0] w1c;
    logic [7:0] sample;
    logic       next_irq;
    logic       all_diff;
    if (rst) begin
      model_reset();
    end else begin
      pin_hist.push_front(sw_in);
      while (pin_hist.size() > 2 + DEB) void'(pin_hist.pop_back());
      new_stable = m_stable;
      for (int b = 0; b < WIDTH; b++) begin
        all_diff = 1'b1;
        for (int i = 2; i < 2 + DEB; i++) begin
          sample = pin_hist[i];
          if (sample[b] == m_stable[b]) all_diff = 1'b0;
        end
        if (all_diff) new_stable[b] = ~m_stable[b];
      end
      if (bus.avs_read && !bus.avs_write) begin
        m_rdv = 1'b1;
        m_rd  = model_reg(bus.avs_address);
      end else begin
        m_rdv = 1'b0;
      end
      next_irq = |(m_edge & m_mask);
      w1c = 8'h00;
      if (bus.avs_write) begin
        case (bus.avs_address)
          2'd1:    m_led  = bus.avs_writedata[7:0];
          2'd2:    m_mask = bus.avs_writedata[7:0];
          2'd3:    w1c    = bus.avs_writedata[7:0];
          default: ;
        endcase
      end
      m_edge   = (m_edge & ~w1c) | (new_stable & ~m_stable);
      m_stable = new_stable;
      m_irq    = next_irq;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, then check all outputs #1 after the edge.
  task automatic applyStimulus(input logic r, input logic rd, input logic wr,
                               input logic [1:0] a, input logic [31:0] wd);
    rst               = r;
    bus.avs_read      = rd;
    bus.avs_write     = wr;
    bus.avs_address   = a;
    bus.avs_writedata = wd;
    model_step();
    @(posedge clk);
    #1;
    checkOutput("model_led",   {24'h0, led_out}, {24'h0, m_led});
    checkOutput("model_irq",   {31'h0, irq}, {31'h0, m_irq});
    checkOutput("model_rdv",   {31'h0, bus.avs_readdatavalid}, {31'h0, m_rdv});
    checkOutput("model_rdata", bus.avs_readdata, m_rd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
  endtask

  task automatic do_read(input logic [1:0] a);
    applyStimulus(1'b0, 1'b1, 1'b0, a, 32'h0);
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    applyStimulus(1'b0, 1'b0, 1'b1, a, d);
  endtask

  initial begin
    int op;
    model_reset();
    sw_in = 8'h00;
    $display("[TB] start");

    applyStimulus(1'b1, 1'b1, 1'b0, 2'd1, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 32'h0);
    checkOutput("rst_led", {24'h0, led_out}, 32'h0);
    checkOutput("rst_irq", {31'h0, irq}, 32'h0);
    checkOutput("rst_rdv", {31'h0, bus.avs_readdatavalid}, 32'h0);

    do_read(2'd0);
    checkOutput("rd_sw_reset", bus.avs_readdata, 32'h0);
    checkOutput("rd_sw_valid", {31'h0, bus.avs_readdatavalid}, 32'h1);

    do_write(2'd1, 32'hFFFF_FFA5);
    checkOutput("led_write", {24'h0, led_out}, 32'hA5);
    do_read(2'd1);
    checkOutput("rd_led", bus.avs_readdata, 32'h0000_00A5);
    checkOutput("rd_led_valid", {31'h0, bus.avs_readdatavalid}, 32'h1);
    idle(1);
    checkOutput("rdv_one_cycle", {31'h0, bus.avs_readdatavalid}, 32'h0);

    sw_in[0] = 1'b1;
    idle(5);
    do_read(2'd0);
    checkOutput("sw_before_c6", bus.avs_readdata, 32'h0);
    do_read(2'd0);
    checkOutput("sw_at_c6", bus.avs_readdata, 32'h1);

    sw_in[1] = 1'b1;
    idle(3);
    sw_in[1] = 1'b0;
    idle(10);
    do_read(2'd0);
    checkOutput("glitch_sw", bus.avs_readdata, 32'h1);
    do_read(2'd3);
    checkOutput("glitch_edge", bus.avs_readdata, 32'h1);

    sw_in[0] = 1'b0;
    idle(8);
    do_write(2'd3, 32'hFF);
    do_read(2'd3);
    checkOutput("edge_cleared", bus.avs_readdata, 32'h0);
    do_write(2'd2, 32'h01);
    idle(1);
    sw_in[0] = 1'b1;
    idle(6);
    checkOutput("irq_before", {31'h0, irq}, 32'h0);
    idle(1);
    checkOutput("irq_raised", {31'h0, irq}, 32'h1);
    do_read(2'd3);
    checkOutput("edge_bit0", bus.avs_readdata, 32'h1);
    do_write(2'd3, 32'h01);
    idle(1);
    checkOutput("irq_cleared", {31'h0, irq}, 32'h0);
    do_read(2'd3);
    checkOutput("edge_w1c", bus.avs_readdata, 32'h0);

    sw_in[2] = 1'b1;
    idle(5);
    do_write(2'd3, 32'h04);
    do_read(2'd3);
    checkOutput("set_beats_w1c", bus.avs_readdata, 32'h4);

    applyStimulus(1'b0, 1'b1, 1'b1, 2'd1, 32'h5A);
    checkOutput("rw_no_rdv", {31'h0, bus.avs_readdatavalid}, 32'h0);
    checkOutput("rw_led", {24'h0, led_out}, 32'h5A);

    do_write(2'd2, 32'hFF);
    do_write(2'd1, 32'h3C);
    sw_in[3] = 1'b1;
    idle(2);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 32'h0);
    checkOutput("mid_rst_led", {24'h0, led_out}, 32'h0);
    checkOutput("mid_rst_irq", {31'h0, irq}, 32'h0);
    checkOutput("mid_rst_rdv", {31'h0, bus.avs_readdatavalid}, 32'h0);
    do_read(2'd0);
    checkOutput("mid_rst_sw", bus.avs_readdata, 32'h0);
    idle(4);
    do_read(2'd3);
    checkOutput("redebounce_early", bus.avs_readdata, 32'h0);
    do_read(2'd3);
    checkOutput("redebounce_edge", bus.avs_readdata, 32'h0D);

    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 9) == 0) sw_in = sw_in ^ (8'h01 << $urandom_range(0, 7));
      op = int'($urandom_range(0, 7));
      if ($urandom_range(0, 299) == 0)
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 32'h0);
      else
        applyStimulus(1'b0, (op < 2) || (op == 4), (op == 2) || (op == 3) || (op == 4),
                      2'($urandom_range(0, 3)), $urandom);
    end

    bus.avs_read  = 1'b0;
    bus.avs_write = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
